// File: rtl/ins_fetcher_pkg.sv
// Shared widths, FSM state type and PC helper for the instruction fetcher.
package ins_fetcher_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INS_WIDTH  = 32;

  // Word-aligned fetches: the two byte-offset bits never reach the cache.
  localparam int unsigned WORD_ADDR_WIDTH = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_WAIT = 2'd1,
    DROP      = 2'd2
  } fetch_state_e;

  // Sequential next-PC; the add wraps naturally modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/ins_fetcher_icache.sv
// Direct-mapped instruction cache: one word per line, async read, single write port.
module icache
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WORD_ADDR_WIDTH-1:0] rd_word_addr_i,
  output logic                       hit_o,
  output logic [INS_WIDTH-1:0]       rd_data_o,
  input  logic                       wr_en_i,
  input  logic [WORD_ADDR_WIDTH-1:0] wr_word_addr_i,
  input  logic [INS_WIDTH-1:0]       wr_data_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = WORD_ADDR_WIDTH - INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [INS_WIDTH-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;

  assign rd_idx = rd_word_addr_i[INDEX_BITS-1:0];
  assign rd_tag = rd_word_addr_i[WORD_ADDR_WIDTH-1:INDEX_BITS];
  assign wr_idx = wr_word_addr_i[INDEX_BITS-1:0];
  assign wr_tag = wr_word_addr_i[WORD_ADDR_WIDTH-1:INDEX_BITS];

  // Lookup is combinational so a hit can issue in the same cycle the PC is presented.
  always_comb begin
    hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_data_o = data_q[rd_idx];
  end

  // Valid bits are the only cache state that needs clearing on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetcher: sequential PC, I-cache hit path, miss handling with
// redirect-driven abort of in-flight memory requests.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int unsigned ICACHE_INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic                  enable_to_mem,
  output logic [ADDR_WIDTH-1:0] addr_to_mem,
  input  logic                  enable_from_mem,
  input  logic [INS_WIDTH-1:0]  ins_from_mem,
  input  logic                  stall_from_issue,
  input  logic                  jump_enable,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  ins_valid,
  output logic [INS_WIDTH-1:0]  ins_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  mem_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  ins_valid_q;
  logic [INS_WIDTH-1:0]  ins_q;
  logic [ADDR_WIDTH-1:0] pc_out_q;

  logic                  cache_hit;
  logic [INS_WIDTH-1:0]  cache_data;
  logic                  fill_en_d;
  logic [ADDR_WIDTH-1:0] pc_next_d;

  assign pc_next_d = next_pc(pc_q);

  // A fill is only accepted for the request still wanted: a redirect in the
  // same cycle discards it, and a response during DROP never matches this state.
  always_comb begin
    fill_en_d = rdy && !rst && !jump_enable && (state_q == MISS_WAIT) && enable_from_mem;
  end

  icache #(
    .INDEX_BITS (ICACHE_INDEX_BITS)
  ) u_icache (
    .clk_i          (clk),
    .rst_i          (rst),
    .rd_word_addr_i (pc_q[ADDR_WIDTH-1:2]),
    .hit_o          (cache_hit),
    .rd_data_o      (cache_data),
    .wr_en_i        (fill_en_d),
    .wr_word_addr_i (pc_q[ADDR_WIDTH-1:2]),
    .wr_data_i      (ins_from_mem)
  );

  // Fetch FSM with registered outputs; redirect outranks every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      ins_valid_q <= 1'b0;
      ins_q       <= '0;
      pc_out_q    <= '0;
    end else if (rdy) begin
      ins_valid_q <= 1'b0;
      if (jump_enable) begin
        pc_q     <= jump_addr;
        mem_en_q <= 1'b0;
        // Only an aborted request needs the extra quiet cycle before re-requesting.
        if (state_q == MISS_WAIT) begin
          state_q <= DROP;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cache_hit) begin
              if (!stall_from_issue) begin
                ins_valid_q <= 1'b1;
                ins_q       <= cache_data;
                pc_out_q    <= pc_q;
                pc_q        <= pc_next_d;
              end
            end else begin
              mem_en_q   <= 1'b1;
              mem_addr_q <= pc_q;
              state_q    <= MISS_WAIT;
            end
          end
          MISS_WAIT: begin
            // The filled line issues through the hit path on a later cycle.
            if (enable_from_mem) begin
              mem_en_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
          DROP: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign enable_to_mem = mem_en_q;
  assign addr_to_mem   = mem_addr_q;
  assign ins_valid     = ins_valid_q;
  assign ins_out       = ins_q;
  assign pc_out        = pc_out_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher; memory responses are driven by hand.
module tb_ins_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        enable_to_mem;
  logic [31:0] addr_to_mem;
  logic        enable_from_mem;
  logic [31:0] ins_from_mem;
  logic        stall_from_issue;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] pc_out;

  int n_checks;
  int n_fail;

  ins_fetcher #(
    .ICACHE_INDEX_BITS (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .enable_to_mem    (enable_to_mem),
    .addr_to_mem      (addr_to_mem),
    .enable_from_mem  (enable_from_mem),
    .ins_from_mem     (ins_from_mem),
    .stall_from_issue (stall_from_issue),
    .jump_enable      (jump_enable),
    .jump_addr        (jump_addr),
    .ins_valid        (ins_valid),
    .ins_out          (ins_out),
    .pc_out           (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request for a must be visible now; answer after lat cycles, then expect the issue.
  task automatic serve(input logic [31:0] a, input int lat);
    check("req_en", {31'b0, enable_to_mem}, 32'd1);
    check("req_addr", addr_to_mem, a);
    for (int i = 1; i < lat; i++) begin
      tick();
      check("hold_en", {31'b0, enable_to_mem}, 32'd1);
      check("hold_addr", addr_to_mem, a);
      check("hold_iv", {31'b0, ins_valid}, 32'd0);
    end
    enable_from_mem = 1'b1;
    ins_from_mem    = mem_word(a);
    tick();
    enable_from_mem = 1'b0;
    ins_from_mem    = '0;
    check("rsp_en_drop", {31'b0, enable_to_mem}, 32'd0);
    check("rsp_iv", {31'b0, ins_valid}, 32'd0);
    tick();
    check("fill_iv", {31'b0, ins_valid}, 32'd1);
    check("fill_pc", pc_out, a);
    check("fill_ins", ins_out, mem_word(a));
  endtask

  task automatic expect_issue(input logic [31:0] a);
    check("hit_iv", {31'b0, ins_valid}, 32'd1);
    check("hit_pc", pc_out, a);
    check("hit_ins", ins_out, mem_word(a));
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_en"}, {31'b0, enable_to_mem}, 32'd0);
    check({tag, "_iv"}, {31'b0, ins_valid}, 32'd0);
  endtask

  task automatic expect_req(input logic [31:0] a);
    check("new_req_en", {31'b0, enable_to_mem}, 32'd1);
    check("new_req_addr", addr_to_mem, a);
    check("new_req_iv", {31'b0, ins_valid}, 32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    rdy              = 1'b1;
    enable_from_mem  = 1'b0;
    ins_from_mem     = '0;
    stall_from_issue = 1'b0;
    jump_enable      = 1'b0;
    jump_addr        = '0;

    // Reset state
    tick();
    tick();
    check("rst_en", {31'b0, enable_to_mem}, 32'd0);
    check("rst_addr", addr_to_mem, 32'h0);
    check("rst_iv", {31'b0, ins_valid}, 32'd0);
    check("rst_ins", ins_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);

    // Cold start: miss at 0, six-cycle response, issue, then request 0x4
    rst = 1'b0;
    tick();
    serve(32'h0, 6);
    tick();
    expect_req(32'h4);

    // Fill 0x4..0xC, abort the 0x10 miss by redirecting to 0, then stream hits
    serve(32'h4, 2);
    tick();
    serve(32'h8, 1);
    tick();
    serve(32'hC, 2);
    tick();
    expect_req(32'h10);
    jump_enable = 1'b1;
    jump_addr   = 32'h0;
    tick();
    jump_enable = 1'b0;
    expect_quiet("abort10_jump");
    tick();
    expect_quiet("abort10_drop");
    tick();
    expect_issue(32'h0);
    tick();
    expect_issue(32'h4);
    tick();
    expect_issue(32'h8);
    tick();
    expect_issue(32'hC);
    tick();
    expect_req(32'h10);
    serve(32'h10, 3);

    // Redirect from IDLE (no DROP cycle), then back-pressure during hits
    jump_enable = 1'b1;
    jump_addr   = 32'h0;
    tick();
    jump_enable = 1'b0;
    expect_quiet("idle_jump");
    tick();
    expect_issue(32'h0);
    stall_from_issue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_quiet("stall");
      check("stall_pc_hold", pc_out, 32'h0);
    end
    stall_from_issue = 1'b0;
    tick();
    expect_issue(32'h4);
    tick();
    expect_issue(32'h8);
    tick();
    expect_issue(32'hC);
    tick();
    expect_issue(32'h10);
    tick();
    expect_req(32'h14);

    // Abort to 0x100 with the late response arriving during DROP
    jump_enable = 1'b1;
    jump_addr   = 32'h100;
    tick();
    jump_enable = 1'b0;
    expect_quiet("abort_jump");
    enable_from_mem = 1'b1;
    ins_from_mem    = mem_word(32'h14);
    tick();
    enable_from_mem = 1'b0;
    ins_from_mem    = '0;
    expect_quiet("abort_drop");
    tick();
    expect_req(32'h100);
    serve(32'h100, 4);
    tick();
    expect_req(32'h104);

    // Response coincident with the redirect is discarded; 0x14 must still miss
    jump_enable     = 1'b1;
    jump_addr       = 32'h14;
    enable_from_mem = 1'b1;
    ins_from_mem    = mem_word(32'h104);
    tick();
    jump_enable     = 1'b0;
    enable_from_mem = 1'b0;
    ins_from_mem    = '0;
    expect_quiet("coinc_jump");
    tick();
    expect_quiet("coinc_drop");
    tick();
    expect_req(32'h14);
    serve(32'h14, 2);
    tick();
    expect_req(32'h18);

    // Conflict: 0x0 was displaced by 0x100, then 0x40 displaces 0x0 again
    jump_enable = 1'b1;
    jump_addr   = 32'h0;
    tick();
    jump_enable = 1'b0;
    tick();
    tick();
    expect_req(32'h0);
    serve(32'h0, 3);
    jump_enable = 1'b1;
    jump_addr   = 32'h40;
    tick();
    jump_enable = 1'b0;
    expect_quiet("jump40");
    tick();
    expect_req(32'h40);
    serve(32'h40, 2);
    tick();
    expect_req(32'h44);
    jump_enable = 1'b1;
    jump_addr   = 32'h0;
    tick();
    jump_enable = 1'b0;
    tick();
    tick();
    expect_req(32'h0);

    // rdy low for five cycles mid-miss: everything frozen, even a redirect
    rdy         = 1'b0;
    jump_enable = 1'b1;
    jump_addr   = 32'h200;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_req(32'h0);
      check("frz_pc_out", pc_out, 32'h40);
      check("frz_ins_out", ins_out, mem_word(32'h40));
    end
    rdy         = 1'b1;
    jump_enable = 1'b0;
    tick();
    expect_req(32'h0);
    serve(32'h0, 2);

    // PC wrap: 0xFFFFFFFC is followed by 0x0 (a hit)
    jump_enable = 1'b1;
    jump_addr   = 32'hFFFF_FFFC;
    tick();
    jump_enable = 1'b0;
    expect_quiet("jump_wrap");
    tick();
    expect_req(32'hFFFF_FFFC);
    serve(32'hFFFF_FFFC, 2);
    tick();
    expect_issue(32'h0);

    // Reset during MISS_WAIT drops the request and clears the cache
    jump_enable = 1'b1;
    jump_addr   = 32'h300;
    tick();
    jump_enable = 1'b0;
    tick();
    expect_req(32'h300);
    rst = 1'b1;
    tick();
    expect_quiet("mid_rst");
    check("mid_rst_addr", addr_to_mem, 32'h0);
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_ins", ins_out, 32'h0);
    rst = 1'b0;
    tick();
    expect_req(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_fetcher.md
INS_FETCHER -- requirements
Module: ins_fetcher

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, rst; rdy is a global enable (clock and reset first).
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ICACHE_INDEX_BITS, 4, log2 of direct-mapped I-cache lines (16 lines, one 32-bit instruction each).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  when low, all state holds.
- enable_to_mem  out  1  fetch request to memory controller; held high until response or abort.
- addr_to_mem  out  `ADDR_WIDTH  byte address of requested instruction (word aligned).
- enable_from_mem  in  1  one-cycle pulse: ins_from_mem valid.
- ins_from_mem  in  `INS_WIDTH  fetched instruction.
- stall_from_issue  in  1  downstream instruction queue full; no new output this cycle.
- jump_enable  in  1  redirect pulse (mispredict/branch) from ROB.
- jump_addr  in  `ADDR_WIDTH  redirect target.
- ins_valid  out  1  one-cycle pulse: ins_out/pc_out valid.
- ins_out  out  `INS_WIDTH  instruction to decoder.
- pc_out  out  `ADDR_WIDTH  address of ins_out.

Function
REQ-004 The block SHALL keep a PC register; next-PC policy is PC+4 (no prediction).
REQ-005 The block SHALL implement states IDLE, MISS_WAIT, DROP.
REQ-006 In IDLE, when the cache hits on PC and stall_from_issue=0, the block SHALL register ins_valid=1, ins_out=cached word, pc_out=PC next edge, and PC<=PC+4 (one instruction per cycle on hits).
REQ-007 In IDLE, on a miss, the block SHALL set enable_to_mem=1, addr_to_mem=PC, and enter MISS_WAIT.
REQ-008 In MISS_WAIT, enable_to_mem and addr_to_mem SHALL remain constant until enable_from_mem=1.
REQ-009 On enable_from_mem=1 in MISS_WAIT, the block SHALL write the line (valid, tag=PC upper bits, data), drop enable_to_mem on the next edge, and return to IDLE; the instruction issues via the hit path (earliest the following cycle).
REQ-010 enable_to_mem SHALL be low for at least one cycle between any two requests, because the controller re-starts a fetch if enable is high when it returns to stall.
REQ-011 jump_enable=1 SHALL take priority over every event: PC<=jump_addr, ins_valid<=0 the next edge, and any in-flight request is aborted.
REQ-012 Abort from MISS_WAIT SHALL drive enable_to_mem=0 and enter DROP for exactly one cycle, then IDLE; a response arriving in the jump cycle or in DROP SHALL be discarded (no cache write, no output).
REQ-013 jump_enable in IDLE or DROP SHALL update PC only; no DROP cycle is added from IDLE.
REQ-014 stall_from_issue=1 SHALL suppress ins_valid and hold PC; outstanding misses continue and fill the cache.
REQ-015 Cache index SHALL be PC[ICACHE_INDEX_BITS+1:2]; tag SHALL be PC[31:ICACHE_INDEX_BITS+2]; PC[1:0] is ignored.
REQ-016 PC+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-017 ins_valid SHALL be a one-cycle pulse per instruction; no instruction SHALL be issued twice or skipped except across jump.
REQ-018 With rdy=0, no register, including cache contents, SHALL change.

Reset
REQ-019 On rst=1 at a clock edge: PC=0, state=IDLE, enable_to_mem=0, addr_to_mem=0, ins_valid=0, ins_out=0, pc_out=0, all cache valid bits=0; reset SHALL take priority over rdy.
REQ-020 Reset during MISS_WAIT SHALL drop enable_to_mem the next edge; the memory controller aborts on its own.

Structure
REQ-021 `ADDR_WIDTH and `INS_WIDTH SHALL come from the shared define.v; state encodings SHALL be local parameters.
REQ-022 The cache array (valid/tag/data, one read port, one write port, hit output) SHALL be a sub-module, icache.

Verification
REQ-023 Cold start: reset, memory holds 0x00000013 at 0x0 -> request addr 0x0, response after 6 cycles, ins_valid with pc_out=0x0, then request 0x4.
REQ-024 Hit streaming: preload lines 0x0-0xC, stall low -> four consecutive ins_valid cycles, pc_out 0x0, 0x4, 0x8, 0xC.
REQ-025 Abort: jump_enable (target 0x100) during MISS_WAIT for 0x8 -> enable_to_mem low >=1 cycle, late response for 0x8 is discarded, next request addr 0x100.
REQ-026 Back-pressure: stall_from_issue high for 3 cycles during hits -> no ins_valid, PC held; resume at the same pc_out.
REQ-027 Conflict: fetch 0x0, then 0x40 (same index) -> second is a miss and replaces the line; refetch of 0x0 misses again.
REQ-028 rdy low for 5 cycles mid-MISS_WAIT -> outputs and state frozen, completes normally after rdy returns high.
